// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side, memory-side and status signals around mem_arbiter.
// The arbiter uses the slave view; the environment (requesters plus memory) uses the master view.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_address;
    logic [31:0] i_data_read;
    logic        i_data_valid;

    logic        d_req;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic        d_write_enable;
    logic [31:0] d_data_read;
    logic        d_data_valid;

    logic        m_req;
    logic [31:0] m_address;
    logic [31:0] m_data_write;
    logic        m_write_enable;
    logic [31:0] m_data_read;
    logic        m_data_valid;

    logic        err;

    modport slave (
        input  i_req, i_address, d_req, d_address, d_data_write, d_write_enable,
        input  m_data_read, m_data_valid,
        output i_data_read, i_data_valid, d_data_read, d_data_valid,
        output m_req, m_address, m_data_write, m_write_enable, err
    );

    modport master (
        output i_req, i_address, d_req, d_address, d_data_write, d_write_enable,
        output m_data_read, m_data_valid,
        input  i_data_read, i_data_valid, d_data_read, d_data_valid,
        input  m_req, m_address, m_data_write, m_write_enable, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction fetch port and a data port.
// Data wins ties, but at most MAX_D_BURST data grants in a row while a fetch waits.
module mem_arbiter #(
    parameter int unsigned MAX_D_BURST = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam int unsigned SW = ($clog2(MAX_D_BURST + 1) < 3) ? 3 : $clog2(MAX_D_BURST + 1);
    localparam int unsigned WW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          serving, timed_out, done;
    logic [31:0]   resp_data;

    assign serving   = (state_q == SERVE_I) || (state_q == SERVE_D);
    // A real completion on the timeout cycle takes precedence over the abort.
    assign timed_out = serving && !bus.m_data_valid && (wait_q == WAIT_MAX);
    assign done      = serving && (bus.m_data_valid || timed_out);
    assign resp_data = timed_out ? 32'hFFFF_FFFF : bus.m_data_read;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        wait_d   = wait_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        unique case (state_q)
            IDLE: begin
                if (bus.d_req && (!bus.i_req || streak_q != STREAK_MAX)) begin
                    state_d  = SERVE_D;
                    wait_d   = '0;
                    addr_d   = bus.d_address;
                    wdata_d  = bus.d_data_write;
                    we_d     = bus.d_write_enable;
                    if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (bus.i_req) begin
                    state_d  = SERVE_I;
                    wait_d   = '0;
                    addr_d   = bus.i_address;
                    we_d     = 1'b0;
                    streak_d = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (done) begin
                    state_d = IDLE;
                    if (timed_out) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    assign bus.m_req          = serving;
    assign bus.m_address      = addr_q;
    assign bus.m_data_write   = wdata_q;
    assign bus.m_write_enable = we_q;
    assign bus.err            = err_q;

    assign bus.i_data_valid = (state_q == SERVE_I) && done;
    assign bus.d_data_valid = (state_q == SERVE_D) && done;
    assign bus.i_data_read  = resp_data;
    assign bus.d_data_read  = resp_data;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_D_BURST, default 4: max consecutive data grants while an instruction request waits.
REQ-002 Parameter TIMEOUT, default 255: cycles a granted access may wait for m_data_valid before abort.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 i_req  in  1  instruction fetch request; held with i_address until i_data_valid.
REQ-006 i_address  in  32  fetch address.
REQ-007 i_data_read  out  32  fetch data.
REQ-008 i_data_valid  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data request; held with d_address, d_data_write, d_write_enable until d_data_valid.
REQ-010 d_address  in  32  data address.
REQ-011 d_data_write  in  32  store data.
REQ-012 d_write_enable  in  1  1 = store, 0 = load.
REQ-013 d_data_read  out  32  load data.
REQ-014 d_data_valid  out  1  one-cycle data completion pulse (loads and stores).
REQ-015 m_req  out  1  memory request, registered.
REQ-016 m_address  out  32  latched address of granted access.
REQ-017 m_data_write  out  32  latched store data.
REQ-018 m_write_enable  out  1  latched store flag; always 0 for fetches.
REQ-019 m_data_read  in  32  memory read data.
REQ-020 m_data_valid  in  1  memory completion pulse.
REQ-021 err  out  1  sticky timeout flag.

Function
REQ-022 FSM states IDLE, SERVE_I, SERVE_D; m_req = 1 exactly when state is SERVE_I or SERVE_D.
REQ-023 IDLE, no request: remain IDLE.
REQ-024 IDLE, only d_req: go SERVE_D; only i_req: go SERVE_I.
REQ-025 IDLE, both: SERVE_D, unless d_streak == MAX_D_BURST, then SERVE_I.
REQ-026 d_streak (3+ bits, saturating at MAX_D_BURST): +1 per SERVE_D grant; cleared on SERVE_I grant; unchanged by idle cycles.
REQ-027 On grant edge, latch requester's address (and store data/flag for data) into m_address, m_data_write, m_write_enable; held constant for whole access.
REQ-028 SERVE_x with m_data_valid = 1: pulse x_data_valid that same cycle, x_data_read = m_data_read combinationally, next state IDLE.
REQ-029 Grant-to-grant minimum is one IDLE cycle (request to next m_req latency one cycle from IDLE).
REQ-030 i_data_valid and d_data_valid never both 1; never asserted in IDLE.
REQ-031 m_data_valid in IDLE ignored, no requester pulse.
REQ-032 Wait counter cleared on grant, +1 per SERVE cycle without m_data_valid; at TIMEOUT: pulse x_data_valid with x_data_read = 32'hFFFF_FFFF, set err, go IDLE.
REQ-033 m_data_valid arriving on the TIMEOUT cycle wins: normal completion, err unchanged.
REQ-034 err cleared only by reset.
REQ-035 Requester dropping req mid-access does not abort; access completes, pulse still issued.

Reset
REQ-036 reset_n low: state IDLE, m_req 0, m_address 0, m_data_write 0, m_write_enable 0, d_streak 0, wait counter 0, err 0, both valid outputs 0, immediately and asynchronously.
REQ-037 Reset mid-access abandons it; no completion pulse after release; first post-reset grant follows REQ-024/025.

Verification
REQ-038 i_req, i_address=0x100; m_data_valid 3 cycles after m_req with 0xCAFE0001 -> m_address 0x100, m_write_enable 0, i_data_valid 1 cycle with 0xCAFE0001, then IDLE.
REQ-039 d_req store, d_address=0x2000, d_data_write=0x55AA55AA -> m_write_enable 1, m_data_write 0x55AA55AA; d_data_valid on m_data_valid.
REQ-040 i_req and d_req held continuously, memory responds in 1 cycle, MAX_D_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-041 TIMEOUT=8, no m_data_valid after data grant -> d_data_valid with 0xFFFFFFFF after 8 SERVE cycles, err 1 until reset.
REQ-042 reset_n pulsed low during SERVE_I -> m_req 0 immediately; late m_data_valid after release yields no i_data_valid.
REQ-043 m_data_valid while IDLE, no requests -> no valid pulse, state IDLE.
